// File: rtl/gshare_btb_predictor_pkg.sv
// Shared types and constants for the gshare + BTB front-end predictor.
// Optional statistics counters are enabled with the BP_STATS_EN macro.
package gshare_btb_predictor_pkg;

  localparam int BP_XLEN      = 32;
  localparam int BP_FETCH_W   = 3;
  localparam int BP_BTB_IDX   = 4;
  localparam int BP_PHT_IDX   = 8;
  localparam int BP_GHR_W     = 8;

  // The BTB entry struct is sized from these, so the top-level parameters
  // must stay at their defaults unless these are changed together with them.
  localparam int BP_TAG_W     = BP_XLEN - BP_BTB_IDX - 2;
  localparam int BP_BTB_DEPTH = 1 << BP_BTB_IDX;
  localparam int BP_PHT_DEPTH = 1 << BP_PHT_IDX;

  typedef enum logic [1:0] {
    STRONG_NT = 2'd0,
    WEAK_NT   = 2'd1,
    WEAK_T    = 2'd2,
    STRONG_T  = 2'd3
  } BP_COUNTER;

  typedef struct packed {
    logic                valid;
    logic [BP_TAG_W-1:0] tag;
    logic [BP_XLEN-1:0]  target;
  } BTB_ENTRY;

  // Upper half of the counter encoding means predict taken.
  function automatic logic counter_taken(input BP_COUNTER c);
    return (c == WEAK_T) || (c == STRONG_T);
  endfunction

  // 32-bit add that sticks at all-ones instead of wrapping.
  function automatic logic [31:0] sat_add32(input logic [31:0] a, input logic [31:0] b);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    return sum[32] ? 32'hFFFF_FFFF : sum[31:0];
  endfunction

endpackage

// File: rtl/gshare_btb_predictor_sat_counter.sv
// Two-bit saturating direction counter next-state function.
module bp_sat_counter
  import gshare_btb_predictor_pkg::*;
(
  input  BP_COUNTER state,
  input  logic      taken,
  output BP_COUNTER next_state
);

  // Step one position toward the resolved direction, holding at the ends.
  always_comb begin
    next_state = state;
    case (state)
      STRONG_NT: next_state = taken ? WEAK_NT  : STRONG_NT;
      WEAK_NT:   next_state = taken ? WEAK_T   : STRONG_NT;
      WEAK_T:    next_state = taken ? STRONG_T : WEAK_NT;
      STRONG_T:  next_state = taken ? STRONG_T : WEAK_T;
      default:   next_state = WEAK_NT;
    endcase
  end

endmodule

// File: rtl/gshare_btb_predictor.sv
// Gshare direction predictor with a direct-mapped BTB, speculative global
// history and snapshot-based history recovery on mispredict.
// Define BP_STATS_EN to add lookup/hit/mispredict statistics outputs.
module gshare_btb_predictor
  import gshare_btb_predictor_pkg::*;
#(
  parameter int FETCH_W = BP_FETCH_W,
  parameter int BTB_IDX = BP_BTB_IDX,
  parameter int PHT_IDX = BP_PHT_IDX,
  parameter int GHR_W   = BP_GHR_W,
  parameter int XLEN    = BP_XLEN
) (
  input  logic                            clock,
  input  logic                            reset,
  input  logic [FETCH_W-1:0]              fetch_EN,
  input  logic [FETCH_W-1:0][XLEN-1:0]    fetch_pc,
  output logic [FETCH_W-1:0]              predict_found,
  output logic [FETCH_W-1:0]              predict_direction,
  output logic [FETCH_W-1:0][XLEN-1:0]    predict_pc,
  output logic [FETCH_W-1:0][GHR_W-1:0]   predict_ghr,
  input  logic [FETCH_W-1:0]              alloc_EN,
  input  logic [FETCH_W-1:0][XLEN-1:0]    alloc_pc,
  input  logic                            update_EN,
  input  logic [XLEN-1:0]                 update_pc,
  input  logic                            update_direction,
  input  logic [XLEN-1:0]                 update_target,
  input  logic [GHR_W-1:0]                update_ghr,
  input  logic                            update_mispredict
`ifdef BP_STATS_EN
  ,
  output logic [31:0]                     stat_lookups,
  output logic [31:0]                     stat_hits,
  output logic [31:0]                     stat_mispredicts
`endif
);

  localparam int TAG_W     = XLEN - BTB_IDX - 2;
  localparam int BTB_DEPTH = 1 << BTB_IDX;
  localparam int PHT_DEPTH = 1 << PHT_IDX;

  BTB_ENTRY         btb [BTB_DEPTH];
  BP_COUNTER        pht [PHT_DEPTH];
  logic [GHR_W-1:0] ghr;

  logic [FETCH_W-1:0]              found;
  logic [FETCH_W-1:0]              direction;
  logic [FETCH_W-1:0][XLEN-1:0]    target;
  logic [FETCH_W-1:0][GHR_W-1:0]   slot_ghr;
  logic [GHR_W-1:0]                fetch_ghr_next;

  logic [FETCH_W-1:0][BTB_IDX-1:0] alloc_idx;
  logic [FETCH_W-1:0][TAG_W-1:0]   alloc_tag;
  logic [FETCH_W-1:0]              alloc_hit;

  logic [BTB_IDX-1:0] update_btb_idx;
  logic               update_hit;
  logic [PHT_IDX-1:0] update_pht_idx;
  BP_COUNTER          update_ctr;
  BP_COUNTER          update_ctr_next;
  logic               recover;

  logic unused_pc_bits;

  // Walk the bundle oldest to youngest, threading the speculative history
  // through each BTB hit and killing everything behind the first taken slot.
  always_comb begin
    BTB_ENTRY         entry;
    BP_COUNTER        ctr;
    logic [GHR_W-1:0] hist;
    logic             taken_seen;
    found          = '0;
    direction      = '0;
    target         = '0;
    slot_ghr       = '0;
    entry          = '0;
    ctr            = WEAK_NT;
    hist           = ghr;
    taken_seen     = 1'b0;
    for (int i = FETCH_W - 1; i >= 0; i--) begin
      slot_ghr[i] = hist;
      entry = btb[fetch_pc[i][BTB_IDX+1:2]];
      ctr   = pht[fetch_pc[i][PHT_IDX+1:2] ^ PHT_IDX'(hist)];
      if (fetch_EN[i] && !taken_seen && entry.valid &&
          (entry.tag == fetch_pc[i][XLEN-1:BTB_IDX+2])) begin
        found[i]     = 1'b1;
        direction[i] = counter_taken(ctr);
        if (counter_taken(ctr)) begin
          target[i]  = entry.target;
          taken_seen = 1'b1;
        end
        hist = {hist[GHR_W-2:0], counter_taken(ctr)};
      end
    end
    fetch_ghr_next = hist;
  end

  // Outputs are forced quiet while reset is held.
  assign predict_found     = reset ? '0 : found;
  assign predict_direction = reset ? '0 : direction;
  assign predict_pc        = reset ? '0 : target;
  assign predict_ghr       = reset ? '0 : slot_ghr;

  // Dispatch-side hit detection against the registered BTB contents.
  always_comb begin
    alloc_idx = '0;
    alloc_tag = '0;
    alloc_hit = '0;
    for (int s = 0; s < FETCH_W; s++) begin
      alloc_idx[s] = alloc_pc[s][BTB_IDX+1:2];
      alloc_tag[s] = alloc_pc[s][XLEN-1:BTB_IDX+2];
      alloc_hit[s] = btb[alloc_idx[s]].valid && (btb[alloc_idx[s]].tag == alloc_tag[s]);
    end
  end

  assign update_btb_idx = update_pc[BTB_IDX+1:2];
  assign update_hit     = btb[update_btb_idx].valid &&
                          (btb[update_btb_idx].tag == update_pc[XLEN-1:BTB_IDX+2]);
  assign update_pht_idx = update_pc[PHT_IDX+1:2] ^ PHT_IDX'(update_ghr);
  assign update_ctr     = pht[update_pht_idx];
  assign recover        = update_EN && update_mispredict;

  bp_sat_counter u_update_ctr (
    .state      (update_ctr),
    .taken      (update_direction),
    .next_state (update_ctr_next)
  );

  // Speculative history: a mispredict restores from the branch snapshot and
  // overrides whatever this cycle's fetch bundle would have shifted in.
  always_ff @(posedge clock) begin
    if (reset) begin
      ghr <= '0;
    end else if (recover) begin
      ghr <= {update_ghr[GHR_W-2:0], update_direction};
    end else begin
      ghr <= fetch_ghr_next;
    end
  end

  // BTB writes: allocations oldest to youngest so the youngest aliasing slot
  // lands last, then the resolve-time target write on top of them.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int e = 0; e < BTB_DEPTH; e++) begin
        btb[e] <= '0;
      end
    end else begin
      for (int s = FETCH_W - 1; s >= 0; s--) begin
        if (alloc_EN[s] && !alloc_hit[s]) begin
          btb[alloc_idx[s]].valid  <= 1'b1;
          btb[alloc_idx[s]].tag    <= alloc_tag[s];
          btb[alloc_idx[s]].target <= '0;
        end
      end
      if (update_EN && update_hit) begin
        btb[update_btb_idx].target <= update_target;
      end
    end
  end

  // PHT training on every resolved branch, regardless of BTB hit.
  always_ff @(posedge clock) begin
    if (reset) begin
      for (int p = 0; p < PHT_DEPTH; p++) begin
        pht[p] <= WEAK_NT;
      end
    end else if (update_EN) begin
      pht[update_pht_idx] <= update_ctr_next;
    end
  end

  // The two byte-offset bits of every PC never select state.
  always_comb begin
    unused_pc_bits = ^update_pc[1:0];
    for (int s = 0; s < FETCH_W; s++) begin
      unused_pc_bits = unused_pc_bits ^ (^fetch_pc[s][1:0]) ^ (^alloc_pc[s][1:0]);
    end
  end

`ifdef BP_STATS_EN
  // Saturating activity counters for performance analysis.
  always_ff @(posedge clock) begin
    if (reset) begin
      stat_lookups     <= '0;
      stat_hits        <= '0;
      stat_mispredicts <= '0;
    end else begin
      stat_lookups     <= sat_add32(stat_lookups, 32'($countones(fetch_EN)));
      stat_hits        <= sat_add32(stat_hits, 32'($countones(found)));
      stat_mispredicts <= sat_add32(stat_mispredicts, {31'd0, recover});
    end
  end
`endif

endmodule
